// File: rtl/imm_gen_pkg.sv
// Shared opcodes, immediate-format codes and the decoded packet type.
package imm_gen_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // Widest supported XLEN; narrower builds leave the upper bits zero.
  localparam int unsigned IMM_MAX_W = 64;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

  typedef struct packed {
    logic [IMM_MAX_W-1:0] imm;
    imm_type_e            imm_type;
    logic                 illegal;
  } imm_pkt_t;

  // Sign-extend a 32-bit immediate to the maximum width.
  function automatic logic [IMM_MAX_W-1:0] sext64(input logic [31:0] v);
    return {{(IMM_MAX_W-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: format, sign-extended immediate, illegal flag.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter bit          CSR_ZIMM_EN = 1'b1
) (
  input  logic [31:0] instr,
  output imm_pkt_t    pkt
);

  logic [31:0] imm32;

  // Per-opcode immediate extraction; every path defaults to "no immediate".
  always_comb begin
    imm32        = '0;
    pkt.imm_type = IMM_NONE;
    pkt.illegal  = 1'b0;
    case (instr[6:0])
      OP_LOAD, OP_IMM, OP_JALR: begin
        imm32        = {{20{instr[31]}}, instr[31:20]};
        pkt.imm_type = IMM_I;
      end
      OP_STORE: begin
        imm32        = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        pkt.imm_type = IMM_S;
      end
      OP_BRANCH: begin
        imm32        = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        pkt.imm_type = IMM_B;
      end
      OP_LUI, OP_AUIPC: begin
        imm32        = {instr[31:12], 12'b0};
        pkt.imm_type = IMM_U;
      end
      OP_JAL: begin
        imm32        = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        pkt.imm_type = IMM_J;
      end
      OP_SYSTEM: begin
        if (CSR_ZIMM_EN && (instr[14:12] != 3'b000)) begin
          imm32        = {27'b0, instr[19:15]};
          pkt.imm_type = IMM_Z;
        end
      end
      OP_OP, OP_FENCE: begin
        imm32 = '0;
      end
      default: begin
        pkt.illegal = 1'b1;
      end
    endcase
    // zimm has bit 31 clear, so sign extension leaves it zero-extended.
    pkt.imm = (XLEN == 64) ? sext64(imm32) : {32'b0, imm32};
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer and illegal counter.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter bit          CSR_ZIMM_EN = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_val,
  output imm_type_e        imm_type,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_type_e       imm_type;
    logic            illegal;
  } ent_t;

  imm_pkt_t dec_pkt;
  ent_t     dec_ent, m_ent, s_ent;
  logic     m_valid, s_valid, rdy_q;
  logic     m_valid_nxt, s_valid_nxt;
  logic     m_load_in, m_load_s, s_load;
  logic     accept, drain;

  imm_decode #(
    .XLEN        (XLEN),
    .CSR_ZIMM_EN (CSR_ZIMM_EN)
  ) u_dec (
    .instr (instr),
    .pkt   (dec_pkt)
  );

  // Narrow the decoded packet to the configured datapath width.
  always_comb begin
    dec_ent.imm      = dec_pkt.imm[XLEN-1:0];
    dec_ent.imm_type = dec_pkt.imm_type;
    dec_ent.illegal  = dec_pkt.illegal;
  end

  // Upper decoder bits are always zero for a 32-bit build.
  if (XLEN < IMM_MAX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^dec_pkt.imm[IMM_MAX_W-1:XLEN];
  end

  assign accept = in_valid && rdy_q && !flush;
  assign drain  = m_valid && out_ready;

  // Skid control: M feeds the output, S only fills when M is stalled.
  always_comb begin
    m_valid_nxt = m_valid;
    s_valid_nxt = s_valid;
    m_load_in   = 1'b0;
    m_load_s    = 1'b0;
    s_load      = 1'b0;
    if (flush) begin
      m_valid_nxt = 1'b0;
      s_valid_nxt = 1'b0;
    end else if (drain) begin
      if (s_valid) begin
        m_load_s    = 1'b1;
        s_valid_nxt = 1'b0;
      end else if (accept) begin
        m_load_in = 1'b1;
      end else begin
        m_valid_nxt = 1'b0;
      end
    end else if (accept) begin
      if (m_valid) begin
        s_load      = 1'b1;
        s_valid_nxt = 1'b1;
      end else begin
        m_load_in   = 1'b1;
        m_valid_nxt = 1'b1;
      end
    end
  end

  // Buffer state and data registers; in_ready is the registered inverse of S.valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      rdy_q   <= 1'b0;
      m_ent   <= '0;
      s_ent   <= '0;
    end else begin
      m_valid <= m_valid_nxt;
      s_valid <= s_valid_nxt;
      rdy_q   <= !s_valid_nxt;
      if (m_load_s) begin
        m_ent <= s_ent;
      end else if (m_load_in) begin
        m_ent <= dec_ent;
      end
      if (s_load) begin
        s_ent <= dec_ent;
      end
    end
  end

  // Saturating count of illegal instructions taken in (flushed inputs never count).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (accept && dec_ent.illegal && (illegal_cnt != '1)) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = m_valid;
  assign imm_val   = m_ent.imm;
  assign imm_type  = m_ent.imm_type;
  assign illegal   = m_ent.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: a 32-bit and a 64-bit instance share one input stream.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instr;

  logic        rdy32, rdy64, ov32, ov64, il32, il64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  imm_type_e   t32, t64;
  logic [15:0] cnt32;
  logic [1:0]  cnt64;

  int checks = 0;
  int errors = 0;

  // Reference model state: FIFO of accepted instructions plus counters.
  logic [31:0] q[$];
  int unsigned mcnt32, mcnt64;
  bit          rdy_hold;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .CSR_ZIMM_EN(1'b1), .CNT_W(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .instr(instr), .out_valid(ov32), .out_ready(out_ready), .imm_val(imm32),
    .imm_type(t32), .illegal(il32), .illegal_cnt(cnt32));

  imm_gen_pipe #(.XLEN(64), .CSR_ZIMM_EN(1'b1), .CNT_W(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .instr(instr), .out_valid(ov64), .out_ready(out_ready), .imm_val(imm64),
    .imm_type(t64), .illegal(il64), .illegal_cnt(cnt64));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic longint sx(input longint v, input int bits);
    if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
    return v;
  endfunction

  // Immediate rules evaluated as plain field arithmetic.
  function automatic void ref_dec(input logic [31:0] ins, output logic [63:0] imm,
                                  output logic [2:0] ty, output bit ill);
    longint v;
    v = 0; ty = 3'd0; ill = 1'b0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: begin v = sx(longint'(ins[31:20]), 12); ty = 3'd1; end
      7'h23: begin v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12); ty = 3'd2; end
      7'h63: begin
        v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
               longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
        ty = 3'd3;
      end
      7'h37, 7'h17: begin v = sx(longint'(ins[31:12]) * 4096, 32); ty = 3'd4; end
      7'h6F: begin
        v = sx(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
               longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
        ty = 3'd5;
      end
      7'h73: if (ins[14:12] != 3'd0) begin v = longint'(ins[19:15]); ty = 3'd6; end
      7'h33, 7'h0F: v = 0;
      default: ill = 1'b1;
    endcase
    imm = 64'(v);
  endfunction

  task automatic check_state();
    logic [63:0] e; logic [2:0] ty; bit ill;
    chk("in_ready32", 64'(rdy32), 64'(!rdy_hold && q.size() < 2));
    chk("in_ready64", 64'(rdy64), 64'(!rdy_hold && q.size() < 2));
    chk("out_valid32", 64'(ov32), 64'(q.size() > 0));
    chk("out_valid64", 64'(ov64), 64'(q.size() > 0));
    chk("cnt32", 64'(cnt32), 64'(mcnt32));
    chk("cnt64", 64'(cnt64), 64'(mcnt64));
    if (q.size() > 0) begin
      ref_dec(q[0], e, ty, ill);
      chk("imm32", 64'(imm32), e & 64'hFFFF_FFFF);
      chk("imm64", imm64, e);
      chk("type32", 64'(t32), 64'(ty));
      chk("type64", 64'(t64), 64'(ty));
      chk("illegal32", 64'(il32), 64'(ill));
      chk("illegal64", 64'(il64), 64'(ill));
    end
  endtask

  // One clock: predict the edge from current inputs, advance, then compare.
  task automatic tick();
    bit acc, drn, ill; logic [63:0] e; logic [2:0] ty;
    acc = in_valid && !rdy_hold && (q.size() < 2) && !flush;
    drn = (q.size() > 0) && out_ready;
    ref_dec(instr, e, ty, ill);
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back(instr);
        if (ill) begin
          if (mcnt32 < 65535) mcnt32++;
          if (mcnt64 < 3) mcnt64++;
        end
      end
    end
    rdy_hold = 1'b0;
    #1;
    check_state();
  endtask

  task automatic model_reset();
    q.delete(); mcnt32 = 0; mcnt64 = 0; rdy_hold = 1'b1;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [63:0] e32;
    logic [63:0] e64;
    logic [2:0]  ty;
    bit          ill;
  } vec_t;

  vec_t        tbl[12];
  logic [6:0]  ops[12];
  logic [31:0] got[$];
  logic [31:0] r;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    tbl[0]  = '{32'hFFF00093, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0};
    tbl[1]  = '{32'hFE112E23, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0};
    tbl[2]  = '{32'hFE000CE3, 64'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0};
    tbl[3]  = '{32'h001000EF, 64'h0000_0800, 64'h0000_0000_0000_0800, 3'd5, 1'b0};
    tbl[4]  = '{32'h123450B7, 64'h1234_5000, 64'h0000_0000_1234_5000, 3'd4, 1'b0};
    tbl[5]  = '{32'h800000B7, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0};
    tbl[6]  = '{32'h3400D073, 64'h0000_0001, 64'h0000_0000_0000_0001, 3'd6, 1'b0};
    tbl[7]  = '{32'h0000007F, 64'h0000_0000, 64'h0000_0000_0000_0000, 3'd0, 1'b1};
    tbl[8]  = '{32'h00000033, 64'h0000_0000, 64'h0000_0000_0000_0000, 3'd0, 1'b0};
    tbl[9]  = '{32'h0000000F, 64'h0000_0000, 64'h0000_0000_0000_0000, 3'd0, 1'b0};
    tbl[10] = '{32'h00000073, 64'h0000_0000, 64'h0000_0000_0000_0000, 3'd0, 1'b0};
    tbl[11] = '{32'h80008067, 64'hFFFF_F800, 64'hFFFF_FFFF_FFFF_F800, 3'd1, 1'b0};
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F, 7'h7F};

    // Reset held: everything idle, in_ready low.
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(ov32), 64'd0);
    chk("rst_in_ready", 64'(rdy32), 64'd0);
    chk("rst_imm32", 64'(imm32), 64'd0);
    chk("rst_imm64", imm64, 64'd0);
    chk("rst_type", 64'(t32), 64'(IMM_NONE));
    chk("rst_illegal", 64'(il32), 64'd0);
    chk("rst_cnt", 64'(cnt32), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_release", 64'(rdy32), 64'd1);

    // Table vectors back to back: each result one cycle after its input.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; instr = tbl[i].ins;
      tick();
      chk("tbl_valid", 64'(ov32), 64'd1);
      chk("tbl_imm32", 64'(imm32), tbl[i].e32);
      chk("tbl_imm64", imm64, tbl[i].e64);
      chk("tbl_type", 64'(t64), 64'(tbl[i].ty));
      chk("tbl_illegal", 64'(il32), 64'(tbl[i].ill));
    end
    in_valid = 1'b0;
    tick();
    chk("illegal_cnt_one", 64'(cnt32), 64'd1);

    // Five more illegal instructions: narrow counter pins at 3.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; instr = {25'(i + 1), 7'h7F};
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("sat_cnt64", 64'(cnt64), 64'd3);
    chk("sat_cnt32", 64'(cnt32), 64'd6);

    // Backpressure: two accepted, third stalls, then all three drain in order.
    out_ready = 1'b0; in_valid = 1'b1;
    instr = 32'h00100093; tick();
    instr = 32'h00200093; tick();
    chk("bp_ready_low", 64'(rdy32), 64'd0);
    instr = 32'h00300093; tick();
    chk("bp_hold_imm", 64'(imm32), 64'd1);
    out_ready = 1'b1;
    got.delete();
    for (int cyc = 0; cyc < 10 && got.size() < 3; cyc++) begin
      bit acc_now;
      if (ov32) got.push_back(imm32);
      acc_now = in_valid && rdy32;
      tick();
      if (acc_now) in_valid = 1'b0;
    end
    chk("bp_count", 64'(got.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      chk("bp_order", (k < got.size()) ? 64'(got[k]) : 64'hDEAD, 64'(k + 1));
    in_valid = 1'b0;
    tick();

    // Flush with both entries full and a same-cycle input.
    out_ready = 1'b0; in_valid = 1'b1;
    instr = 32'h00500013; tick();
    instr = 32'h00600013; tick();
    flush = 1'b1; instr = 32'h00700013;
    tick();
    chk("flush_valid", 64'(ov32), 64'd0);
    chk("flush_ready", 64'(rdy32), 64'd1);
    // Flush wins over an accept that would otherwise be taken.
    flush = 1'b0; instr = 32'h00800013; tick();
    flush = 1'b1; instr = 32'h0000007F; tick();
    chk("flush_prio_cnt", 64'(cnt32), 64'd6);
    chk("flush_prio_valid", 64'(ov32), 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      instr     = {r[31:7], ($urandom_range(0, 15) == 0) ? 7'($urandom()) : ops[$urandom_range(0, 11)]};
      tick();
    end
    flush = 1'b0;

    // Asynchronous reset in the middle of a stall, between clock edges.
    out_ready = 1'b0; in_valid = 1'b1;
    instr = 32'h0000007F; tick();
    instr = 32'h00900013; tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 64'(ov32), 64'd0);
    chk("arst_ready", 64'(rdy64), 64'd0);
    chk("arst_imm64", imm64, 64'd0);
    chk("arst_cnt32", 64'(cnt32), 64'd0);
    chk("arst_cnt64", 64'(cnt64), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
